// File: rtl/m_cnt_down_mmss_if.sv
// rtl/m_cnt_down_mmss_if.sv - control, load and display bundle for the mm:ss countdown timer
interface m_cnt_down_mmss_if;
    logic       tick;
    logic       load;
    logic       start;
    logic       pause;
    logic [3:0] ld_min_high;
    logic [3:0] ld_min_low;
    logic [3:0] ld_sec_high;
    logic [3:0] ld_sec_low;
    logic [3:0] min_high;
    logic [3:0] min_low;
    logic [3:0] sec_high;
    logic [3:0] sec_low;
    logic       running;
    logic       expired;
    logic       done;

    modport master (
        output tick, load, start, pause,
        output ld_min_high, ld_min_low, ld_sec_high, ld_sec_low,
        input  min_high, min_low, sec_high, sec_low,
        input  running, expired, done
    );

    modport slave (
        input  tick, load, start, pause,
        input  ld_min_high, ld_min_low, ld_sec_high, ld_sec_low,
        output min_high, min_low, sec_high, sec_low,
        output running, expired, done
    );
endinterface

// File: rtl/m_cnt_down_mmss.sv
// rtl/m_cnt_down_mmss.sv - BCD mm:ss countdown timer with expiry flag and optional auto reload
module m_cnt_down_mmss #(
    parameter int MIN_HIGH_MAX = 5,
    parameter bit AUTO_RELOAD  = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    m_cnt_down_mmss_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam logic [3:0] MH_MAX = 4'(MIN_HIGH_MAX);

    state_t     state_q, state_d;
    logic [3:0] mh_q, mh_d, ml_q, ml_d, sh_q, sh_d, sl_q, sl_d;
    logic [3:0] rl_mh_q, rl_mh_d, rl_ml_q, rl_ml_d, rl_sh_q, rl_sh_d, rl_sl_q, rl_sl_d;
    logic       done_q, done_d;
    logic       running_q, expired_q;

    logic [3:0] dec_mh, dec_ml, dec_sh, dec_sl;
    logic [3:0] clp_mh, clp_ml, clp_sh, clp_sl;
    logic       is_zero, is_one;

    function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] mx);
        return (v > mx) ? mx : v;
    endfunction

    assign clp_mh  = clamp(bus.ld_min_high, MH_MAX);
    assign clp_ml  = clamp(bus.ld_min_low,  4'd9);
    assign clp_sh  = clamp(bus.ld_sec_high, 4'd5);
    assign clp_sl  = clamp(bus.ld_sec_low,  4'd9);

    assign is_zero = ({mh_q, ml_q, sh_q, sl_q} == 16'h0000);
    assign is_one  = ({mh_q, ml_q, sh_q, sl_q} == 16'h0001);

    // One-second BCD decrement with borrow rippling from sec_low up to min_high
    always_comb begin
        dec_mh = mh_q;
        dec_ml = ml_q;
        dec_sh = sh_q;
        dec_sl = sl_q;
        if (sl_q != 4'd0) begin
            dec_sl = sl_q - 4'd1;
        end else begin
            dec_sl = 4'd9;
            if (sh_q != 4'd0) begin
                dec_sh = sh_q - 4'd1;
            end else begin
                dec_sh = 4'd5;
                if (ml_q != 4'd0) begin
                    dec_ml = ml_q - 4'd1;
                end else begin
                    dec_ml = 4'd9;
                    dec_mh = mh_q - 4'd1;
                end
            end
        end
    end

    // Next state and digits; load beats pause beats start beats tick
    always_comb begin
        state_d = state_q;
        mh_d    = mh_q;
        ml_d    = ml_q;
        sh_d    = sh_q;
        sl_d    = sl_q;
        rl_mh_d = rl_mh_q;
        rl_ml_d = rl_ml_q;
        rl_sh_d = rl_sh_q;
        rl_sl_d = rl_sl_q;
        done_d  = 1'b0;
        if (bus.load) begin
            mh_d    = clp_mh;
            ml_d    = clp_ml;
            sh_d    = clp_sh;
            sl_d    = clp_sl;
            rl_mh_d = clp_mh;
            rl_ml_d = clp_ml;
            rl_sh_d = clp_sh;
            rl_sl_d = clp_sl;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!bus.pause && bus.start && !is_zero) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.pause) begin
                        state_d = ST_PAUSED;
                    end else if (bus.tick) begin
                        if (is_zero) begin
                            // Only reachable with auto reload: 00:00 has been shown for one tick
                            mh_d = rl_mh_q;
                            ml_d = rl_ml_q;
                            sh_d = rl_sh_q;
                            sl_d = rl_sl_q;
                        end else begin
                            mh_d = dec_mh;
                            ml_d = dec_ml;
                            sh_d = dec_sh;
                            sl_d = dec_sl;
                            if (is_one) begin
                                done_d = 1'b1;
                                if (!AUTO_RELOAD) begin
                                    state_d = ST_EXPIRED;
                                end
                            end
                        end
                    end
                end
                ST_PAUSED: begin
                    if (!bus.pause && bus.start) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_EXPIRED;
                end
            endcase
        end
    end

    // State, digit, reload and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mh_q      <= 4'd0;
            ml_q      <= 4'd0;
            sh_q      <= 4'd0;
            sl_q      <= 4'd0;
            rl_mh_q   <= 4'd0;
            rl_ml_q   <= 4'd0;
            rl_sh_q   <= 4'd0;
            rl_sl_q   <= 4'd0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mh_q      <= mh_d;
            ml_q      <= ml_d;
            sh_q      <= sh_d;
            sl_q      <= sl_d;
            rl_mh_q   <= rl_mh_d;
            rl_ml_q   <= rl_ml_d;
            rl_sh_q   <= rl_sh_d;
            rl_sl_q   <= rl_sl_d;
            done_q    <= done_d;
            running_q <= (state_d == ST_RUN);
            expired_q <= (state_d == ST_EXPIRED);
        end
    end

    assign bus.min_high = mh_q;
    assign bus.min_low  = ml_q;
    assign bus.sec_high = sh_q;
    assign bus.sec_low  = sl_q;
    assign bus.running  = running_q;
    assign bus.expired  = expired_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_m_cnt_down_mmss.sv
// tb/tb_m_cnt_down_mmss.sv - randomized and directed bench for the mm:ss countdown timer
module tb_m_cnt_down_mmss;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXP = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
    logic [15:0] ld_val = 16'h0000;

    int checks = 0;
    int errors = 0;

    int m_val [2];
    int m_rel [2];
    int m_st  [2];
    bit m_done[2];

    m_cnt_down_mmss_if if0 ();
    m_cnt_down_mmss_if if1 ();

    assign if0.tick = tick;   assign if1.tick = tick;
    assign if0.load = load;   assign if1.load = load;
    assign if0.start = start; assign if1.start = start;
    assign if0.pause = pause; assign if1.pause = pause;
    assign {if0.ld_min_high, if0.ld_min_low, if0.ld_sec_high, if0.ld_sec_low} = ld_val;
    assign {if1.ld_min_high, if1.ld_min_low, if1.ld_sec_high, if1.ld_sec_low} = ld_val;

    m_cnt_down_mmss #(.MIN_HIGH_MAX(5), .AUTO_RELOAD(1'b0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
    );

    m_cnt_down_mmss #(.MIN_HIGH_MAX(9), .AUTO_RELOAD(1'b1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    always #5 clk = ~clk;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [15:0] to_bcd(input int secs);
        int mm, ss;
        mm = secs / 60;
        ss = secs % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic logic [15:0] dut_val(input int k);
        if (k == 0) return {if0.min_high, if0.min_low, if0.sec_high, if0.sec_low};
        return {if1.min_high, if1.min_low, if1.sec_high, if1.sec_low};
    endfunction

    // Reference: value kept as plain seconds, status as a simple mode number
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int mhmax, secs;
            mhmax = (k == 0) ? 5 : 9;
            m_done[k] = 1'b0;
            if (!rst_n) begin
                m_val[k] = 0;
                m_rel[k] = 0;
                m_st[k]  = M_IDLE;
            end else if (load) begin
                secs = (imin(int'(ld_val[15:12]), mhmax) * 10 + imin(int'(ld_val[11:8]), 9)) * 60
                     + imin(int'(ld_val[7:4]), 5) * 10 + imin(int'(ld_val[3:0]), 9);
                m_val[k] = secs;
                m_rel[k] = secs;
                m_st[k]  = M_IDLE;
            end else if (m_st[k] == M_IDLE) begin
                if (!pause && start && m_val[k] != 0) m_st[k] = M_RUN;
            end else if (m_st[k] == M_PAUSED) begin
                if (!pause && start) m_st[k] = M_RUN;
            end else if (m_st[k] == M_RUN) begin
                if (pause) begin
                    m_st[k] = M_PAUSED;
                end else if (tick) begin
                    if (m_val[k] == 0) begin
                        m_val[k] = m_rel[k];
                    end else begin
                        m_val[k] = m_val[k] - 1;
                        if (m_val[k] == 0) begin
                            m_done[k] = 1'b1;
                            if (k == 0) m_st[k] = M_EXP;
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Every-cycle comparison of both instances against the reference
    always @(negedge clk) begin
        if (rst_n) begin
            chk("dut0 digits",  32'(dut_val(0)), 32'(to_bcd(m_val[0])));
            chk("dut0 running", 32'(if0.running), 32'(m_st[0] == M_RUN));
            chk("dut0 expired", 32'(if0.expired), 32'(m_st[0] == M_EXP));
            chk("dut0 done",    32'(if0.done),    32'(m_done[0]));
            chk("dut1 digits",  32'(dut_val(1)), 32'(to_bcd(m_val[1])));
            chk("dut1 running", 32'(if1.running), 32'(m_st[1] == M_RUN));
            chk("dut1 expired", 32'(if1.expired), 32'(m_st[1] == M_EXP));
            chk("dut1 done",    32'(if1.done),    32'(m_done[1]));
        end
    end

    task automatic step(input bit ld, input logic [15:0] v, input bit st, input bit ps, input bit tk);
        @(negedge clk);
        #1;
        load = ld; ld_val = v; start = st; pause = ps; tick = tk;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_load(input logic [15:0] v);
        step(1'b1, v, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_tick();
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_start();
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        chk("reset digits0", 32'(dut_val(0)), 32'h0);
        chk("reset flags0", {29'd0, if0.running, if0.expired, if0.done}, 32'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // 1: reset mid-run
        do_load(16'h1234); do_start(); do_tick();
        chk("t1 pre-reset", 32'(dut_val(0)), 32'h1233);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t1 async digits", 32'(dut_val(0)), 32'h0);
        chk("t1 async running", 32'(if0.running), 32'h0);
        @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        do_start();
        chk("t1 start after reset", {15'd0, if0.running, dut_val(0)}, 32'h0);

        // 2: 01:00 to expiry
        do_load(16'h0100); do_start(); do_tick();
        chk("t2 first tick", 32'(dut_val(0)), 32'h0059);
        repeat (58) do_tick();
        chk("t2 at 00:01", 32'(dut_val(0)), 32'h0001);
        do_tick();
        chk("t2 expiry digits", 32'(dut_val(0)), 32'h0);
        chk("t2 expiry flags", {29'd0, if0.running, if0.expired, if0.done}, 32'h3);
        idle();
        chk("t2 done one clk", {29'd0, if0.running, if0.expired, if0.done}, 32'h2);
        do_tick(); do_tick(); do_start();
        chk("t2 hold at zero", {15'd0, if0.expired, dut_val(0)}, 32'h10000);

        // 3: full borrow chain and pause
        do_load(16'h1000); do_start(); do_tick();
        chk("t3 borrow chain", 32'(dut_val(0)), 32'h0959);
        step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        do_tick(); do_tick(); do_tick();
        chk("t3 paused hold", {15'd0, if0.running, dut_val(0)}, 32'h0959);
        do_start(); do_tick();
        chk("t3 resumed", {15'd0, if0.running, dut_val(0)}, 32'h10958);

        // 4: clamping and load priority
        do_load(16'hFFFF);
        chk("t4 clamp dut0", 32'(dut_val(0)), 32'h5959);
        chk("t4 clamp dut1", 32'(dut_val(1)), 32'h9959);
        do_start(); do_tick();
        chk("t4 running tick", 32'(dut_val(0)), 32'h5958);
        step(1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1);
        chk("t4 load wins", {15'd0, if0.running, dut_val(0)}, 32'h05959);

        // 5: auto reload on dut1
        do_load(16'h0002); do_start(); do_tick(); do_tick();
        chk("t5 zero dut1", 32'(dut_val(1)), 32'h0);
        chk("t5 flags dut1", {29'd0, if1.running, if1.expired, if1.done}, 32'h5);
        do_tick();
        chk("t5 reload dut1", {15'd0, if1.running, dut_val(1)}, 32'h10002);
        chk("t5 no expire dut1", 32'(if1.expired), 32'h0);

        // 6: pause+start together, start at zero
        do_load(16'h0005); do_start();
        step(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
        chk("t6 pause wins", 32'(if0.running), 32'h0);
        do_tick();
        chk("t6 paused value", 32'(dut_val(0)), 32'h0005);
        do_start();
        chk("t6 resume", 32'(if0.running), 32'h1);
        do_load(16'h0000); do_start();
        chk("t6 start at zero", {14'd0, if0.running, if0.expired, dut_val(0)}, 32'h0);

        // Randomized traffic against the reference
        for (int i = 0; i < 20000; i++) begin
            logic [15:0] v;
            bit ld;
            ld = ($urandom % 150) == 0;
            if ($urandom % 2 == 0) v = 16'($urandom_range(0, 5));
            else                   v = 16'($urandom);
            step(ld, v, ($urandom % 8) == 0, ($urandom % 30) == 0, ($urandom % 3) == 0);
        end
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
